gerenciador_vidas: RTL and testbench

Life-management controller for the game datapath. It sequences the 3-bit life count through start, damage, bonus and game-over. It owns the life register, applies a damage-immunity window after each hit, and flags game over when lives reach zero. The display and game-logic blocks consume `vidas`, `imune` and `fim_jogo` directly.

---
 rtl/gerenciador_vidas.sv | 113 +++++++++++
 tb/tb_gerenciador_vidas.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_vidas.sv
// Life-management controller: start, damage with immunity window, bonus lives, game over.
// Optional feature macro: BONUS_VIDA_EN (when undefined, the bonus input is ignored).
module gerenciador_vidas #(
  parameter int VIDAS_INICIAIS  = 3,
  parameter int MAX_VIDAS       = 7,
  parameter int COOLDOWN_CICLOS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       dano,
  input  logic       bonus,
  output logic [2:0] vidas,
  output logic       jogando,
  output logic       imune,
  output logic       fim_jogo,
  output logic       dano_aceito,
  output logic [1:0] estado
);

  // Handshake: none. dano, bonus and iniciar are level-sampled on every rising
  // edge; there is no ready/backpressure, dano_aceito reports a hit that was applied.

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    JOGANDO = 2'd1,
    IMUNE   = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t    est;
  logic [7:0] contador;
  logic       bonus_ef;
  logic [3:0] soma;
  logic [2:0] prox_jogando;
  logic [2:0] prox_imune;

`ifdef BONUS_VIDA_EN
  assign bonus_ef = bonus;
`else
  assign bonus_ef = bonus & 1'b0;
`endif

  // Four bits so the sum can exceed the ceiling (or dip) before saturation.
  always_comb begin
    soma = {1'b0, vidas} + {3'b000, bonus_ef} - {3'b000, dano};
    if (vidas == 3'd0 && dano && !bonus_ef)
      soma = 4'd0;
    if (soma > 4'(MAX_VIDAS))
      prox_jogando = 3'(MAX_VIDAS);
    else
      prox_jogando = soma[2:0];
    if ({1'b0, vidas} + {3'b000, bonus_ef} > 4'(MAX_VIDAS))
      prox_imune = 3'(MAX_VIDAS);
    else
      prox_imune = vidas + {2'b00, bonus_ef};
  end

  assign estado = est;

  always_ff @(posedge clock) begin
    if (!reset) begin
      est         <= OCIOSO;
      vidas       <= 3'd0;
      contador    <= 8'd0;
      jogando     <= 1'b0;
      imune       <= 1'b0;
      fim_jogo    <= 1'b0;
      dano_aceito <= 1'b0;
    end else begin
      dano_aceito <= 1'b0;
      case (est)
        OCIOSO, FIM: begin
          if (iniciar) begin
            est      <= JOGANDO;
            vidas    <= 3'(VIDAS_INICIAIS);
            jogando  <= 1'b1;
            imune    <= 1'b0;
            fim_jogo <= 1'b0;
          end
        end
        JOGANDO: begin
          vidas <= prox_jogando;
          if (dano) begin
            dano_aceito <= 1'b1;
            if (prox_jogando == 3'd0) begin
              est      <= FIM;
              jogando  <= 1'b0;
              fim_jogo <= 1'b1;
            end else begin
              est      <= IMUNE;
              imune    <= 1'b1;
              contador <= 8'(COOLDOWN_CICLOS - 1);
            end
          end
        end
        IMUNE: begin
          vidas <= prox_imune;
          if (contador == 8'd0) begin
            est   <= JOGANDO;
            imune <= 1'b0;
          end else begin
            contador <= contador - 8'd1;
          end
        end
        default: begin
          est <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gerenciador_vidas.sv
// Directed bench for gerenciador_vidas with default parameters; bonus checks follow BONUS_VIDA_EN.
module tb_gerenciador_vidas;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       dano;
  logic       bonus;
  logic [2:0] vidas;
  logic       jogando;
  logic       imune;
  logic       fim_jogo;
  logic       dano_aceito;
  logic [1:0] estado;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulsos;

  gerenciador_vidas dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .dano        (dano),
    .bonus       (bonus),
    .vidas       (vidas),
    .jogando     (jogando),
    .imune       (imune),
    .fim_jogo    (fim_jogo),
    .dano_aceito (dano_aceito),
    .estado      (estado)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] v, input logic j,
                         input logic im, input logic f, input logic a);
    chk({tag, ".vidas"},       8'(vidas),       8'(v));
    chk({tag, ".jogando"},     8'(jogando),     8'(j));
    chk({tag, ".imune"},       8'(imune),       8'(im));
    chk({tag, ".fim_jogo"},    8'(fim_jogo),    8'(f));
    chk({tag, ".dano_aceito"}, 8'(dano_aceito), 8'(a));
  endtask

  // One accepted hit followed by the full immunity window (back in JOGANDO).
  task automatic hit();
    dano = 1'b1;
    step();
    dano = 1'b0;
    repeat (4) step();
  endtask

  // Hand-computed per-edge expectations for dano held 12 cycles from vidas=3.
  logic [2:0] exp_v  [12] = '{3'd2,3'd2,3'd2,3'd2,3'd2,3'd1,3'd1,3'd1,3'd1,3'd1,3'd0,3'd0};
  logic       exp_a  [12] = '{1,0,0,0,0,1,0,0,0,0,1,0};
  logic       exp_im [12] = '{1,1,1,1,0,1,1,1,1,0,0,0};
  logic       exp_f  [12] = '{0,0,0,0,0,0,0,0,0,0,1,1};

  initial begin
    reset = 1'b0; iniciar = 1'b0; dano = 1'b0; bonus = 1'b0;
    @(negedge clock);
    step();
    chk_all("reset", 3'd0, 0, 0, 0, 0);
    chk("reset.estado", 8'(estado), 8'd0);

    // Start: vidas and jogando visible right after the sampling edge.
    reset = 1'b1; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk_all("start", 3'd3, 1, 0, 0, 0);
    chk("start.estado", 8'(estado), 8'd1);

    // Held damage: one hit per 5 edges, game over on the third.
    n_pulsos = 0;
    dano = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (dano_aceito) n_pulsos++;
      chk_all($sformatf("held%0d", i), exp_v[i], !exp_f[i], exp_im[i], exp_f[i], exp_a[i]);
    end
    dano = 1'b0;
    chk("held.pulses", 8'(n_pulsos), 8'd3);
    chk("held.estado", 8'(estado), 8'd3);

    // Inputs other than iniciar are ignored in FIM.
    dano = 1'b1; bonus = 1'b1;
    step();
    dano = 1'b0; bonus = 1'b0;
    chk_all("fim_ignore", 3'd0, 0, 0, 1, 0);

    // Restart from FIM.
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk_all("restart", 3'd3, 1, 0, 0, 0);

`ifdef BONUS_VIDA_EN
    // Bonus saturates at 7.
    bonus = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("bonus%0d", i), 8'(vidas), (i < 4) ? 8'(4 + i) : 8'd7);
    end
    bonus = 1'b0;
    // Restart and bring vidas down to 1, then dano+bonus together.
    reset = 1'b0; step(); reset = 1'b1;
    iniciar = 1'b1; step(); iniciar = 1'b0;
    hit();
    hit();
    chk_all("at_one", 3'd1, 1, 0, 0, 0);
    dano = 1'b1; bonus = 1'b1;
    step();
    dano = 1'b0; bonus = 1'b0;
    chk_all("dano_bonus_at_one", 3'd1, 1, 1, 0, 1);
    // Bonus during immunity adds a life without stretching the window.
    bonus = 1'b1;
    step();
    bonus = 1'b0;
    chk_all("bonus_imune", 3'd2, 1, 1, 0, 0);
    repeat (2) step();
    chk("imune_last", 8'(imune), 8'd1);
    step();
    chk("imune_end", 8'(imune), 8'd0);
`else
    // Bonus ignored without the feature.
    bonus = 1'b1;
    repeat (3) step();
    chk("bonus_off", 8'(vidas), 8'd3);
    dano = 1'b1;
    step();
    dano = 1'b0; bonus = 1'b0;
    chk_all("dano_bonus_off", 3'd2, 1, 1, 0, 1);
    repeat (4) step();
    chk_all("window_end", 3'd2, 1, 0, 0, 0);
    reset = 1'b0; step(); reset = 1'b1;
    iniciar = 1'b1; step(); iniciar = 1'b0;
`endif

    // Reset in the middle of immunity, then damage while idle.
    dano = 1'b1;
    step();
    dano = 1'b0;
    chk("pre_reset.imune", 8'(imune), 8'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_all("mid_reset", 3'd0, 0, 0, 0, 0);
    dano = 1'b1;
    step();
    dano = 1'b0;
    chk_all("idle_dano", 3'd0, 0, 0, 0, 0);
    chk("idle.estado", 8'(estado), 8'd0);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk_all("reinit", 3'd3, 1, 0, 0, 0);

    // iniciar is ignored while immune.
    dano = 1'b1;
    step();
    dano = 1'b0; iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk_all("imune_iniciar", 3'd2, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
